// File: rtl/hx8352_init_seq_pkg.sv
// Shared definitions for the HX8352 power-up sequencer: ROM command codes,
// sequencer state encoding and millisecond-to-cycle conversion.
package hx8352_pkg;

   localparam logic [7:0] CMD_CUSTOM_DELAY = 8'hFE;
   localparam logic [7:0] CMD_CUSTOM_DONE  = 8'hFF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RST_LOW,
      S_RST_WAIT,
      S_FETCH,
      S_LATCH,
      S_DECODE,
      S_WR_IDX,
      S_WR_DAT,
      S_DELAY,
      S_DONE
   } state_t;

   function automatic int unsigned ms_cycles(input int unsigned ms, input int unsigned freq);
      return ms * (freq / 1000);
   endfunction

endpackage

// File: rtl/hx8352_init_seq_ms_timer.sv
// Millisecond timer: a load pulse arms an 8-bit ms down-counter driven by a
// MS_DIV-cycle prescaler; expired is high during the final cycle and afterwards.
module ms_timer #(
   parameter int unsigned MS_DIV = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] ms,
   output logic       expired
);

   localparam int unsigned PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(MS_DIV - 1);

   logic [PW-1:0] presc;
   logic [7:0]    cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         cnt   <= '0;
      end else if (load) begin
         presc <= PRESC_MAX;
         cnt   <= ms;
      end else if (cnt != '0) begin
         if (presc == '0) begin
            presc <= PRESC_MAX;
            cnt   <= cnt - 8'd1;
         end else begin
            presc <= presc - PW'(1);
         end
      end
   end

   // Flagged one cycle early so the owner's state change lands on the last cycle.
   always_comb begin
      expired = (cnt == '0) || ((cnt == 8'd1) && (presc == '0));
   end

endmodule

// File: rtl/hx8352_init_seq.sv
// HX8352 power-up sequencer: pulses the panel reset, then walks the init ROM
// issuing index/data bus beats and executing delay/terminator entries locally.
module hx8352_init_seq
   import hx8352_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned RST_LOW_MS  = 10,
   parameter int unsigned RST_WAIT_MS = 120,
   parameter int unsigned ADDR_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              bus_valid,
   output logic              bus_rs,
   output logic [7:0]        bus_data,
   input  logic              bus_ready,
   output logic              lcd_rst_n,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned MS_DIV = ms_cycles(1, CLK_FREQ_HZ);

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_n;
   logic [7:0]        cmd, cmd_n, arg, arg_n;
   logic              err_n, rstn_n, advance;
   logic              tmr_load, tmr_exp;
   logic [7:0]        tmr_ms;

   ms_timer #(.MS_DIV(MS_DIV)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .ms      (tmr_ms),
      .expired (tmr_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rom_addr  <= '0;
         cmd       <= '0;
         arg       <= '0;
         error     <= 1'b0;
         lcd_rst_n <= 1'b1;
      end else begin
         state     <= state_n;
         rom_addr  <= addr_n;
         cmd       <= cmd_n;
         arg       <= arg_n;
         error     <= err_n;
         lcd_rst_n <= rstn_n;
      end
   end

   always_comb begin
      state_n   = state;
      addr_n    = rom_addr;
      cmd_n     = cmd;
      arg_n     = arg;
      err_n     = error;
      rstn_n    = lcd_rst_n;
      advance   = 1'b0;
      tmr_load  = 1'b0;
      tmr_ms    = '0;
      bus_valid = 1'b0;
      bus_rs    = 1'b0;
      bus_data  = '0;

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               err_n    = 1'b0;
               rstn_n   = 1'b0;
               tmr_load = 1'b1;
               tmr_ms   = 8'(RST_LOW_MS);
               state_n  = S_RST_LOW;
            end
         end
         S_RST_LOW: begin
            if (tmr_exp) begin
               rstn_n   = 1'b1;
               tmr_load = 1'b1;
               tmr_ms   = 8'(RST_WAIT_MS);
               state_n  = S_RST_WAIT;
            end
         end
         S_RST_WAIT: begin
            if (tmr_exp) begin
               addr_n  = '0;
               state_n = S_FETCH;
            end
         end
         S_FETCH: state_n = S_LATCH;
         S_LATCH: begin
            cmd_n   = rom_data[15:8];
            arg_n   = rom_data[7:0];
            state_n = S_DECODE;
         end
         S_DECODE: begin
            if (cmd == CMD_CUSTOM_DONE) begin
               state_n = S_DONE;
            end else if (cmd == CMD_CUSTOM_DELAY) begin
               if (arg == '0) begin
                  advance = 1'b1;
               end else begin
                  tmr_load = 1'b1;
                  tmr_ms   = arg;
                  state_n  = S_DELAY;
               end
            end else begin
               state_n = S_WR_IDX;
            end
         end
         S_WR_IDX: begin
            bus_valid = 1'b1;
            bus_data  = cmd;
            if (bus_ready) state_n = S_WR_DAT;
         end
         S_WR_DAT: begin
            bus_valid = 1'b1;
            bus_rs    = 1'b1;
            bus_data  = arg;
            if (bus_ready) advance = 1'b1;
         end
         S_DELAY: begin
            if (tmr_exp) advance = 1'b1;
         end
         default: state_n = S_IDLE;
      endcase

      // Shared end-of-entry step for data beats, zero delays and elapsed delays.
      if (advance) begin
         if (rom_addr == '1) begin
            err_n   = 1'b1;
            state_n = S_DONE;
         end else begin
            addr_n  = rom_addr + ADDR_W'(1);
            state_n = S_FETCH;
         end
      end
   end

   always_comb begin
      busy = (state != S_IDLE) && (state != S_DONE);
      done = (state == S_DONE);
   end

endmodule

// File: tb/tb_hx8352_init_seq.sv
// Self-checking bench for hx8352_init_seq: table vectors, random ROM/ready
// stimulus against a behavioural sequence model, reset and start corner cases.
module tb_hx8352_init_seq;

   localparam int unsigned FREQ     = 4000;
   localparam int unsigned DIV      = FREQ / 1000;
   localparam int unsigned LOW_MS   = 2;
   localparam int unsigned WAIT_MS  = 3;
   localparam int          LOW_CYC  = LOW_MS * DIV;
   localparam int          WAIT_CYC = WAIT_MS * DIV;

   logic        clk, rst, start, bus_ready;
   logic [7:0]  rom_addr, bus_data;
   logic [15:0] rom_data;
   logic        bus_valid, bus_rs, lcd_rst_n, busy, done, error;

   hx8352_init_seq #(
      .CLK_FREQ_HZ (FREQ),
      .RST_LOW_MS  (LOW_MS),
      .RST_WAIT_MS (WAIT_MS),
      .ADDR_W      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .bus_valid (bus_valid),
      .bus_rs    (bus_rs),
      .bus_data  (bus_data),
      .bus_ready (bus_ready),
      .lcd_rst_n (lcd_rst_n),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] rom [256];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int          n_chk = 0;
   int          n_fail = 0;
   int          mode = 0;
   int          stall_run = 0;
   logic        prev_stall = 1'b0;
   logic [9:0]  prev_beat = '0;
   logic [8:0]  beats [$];
   int          low_cnt, rel_cnt, busy_bad;
   logic        low_seen, valid_seen;

   typedef struct {
      logic [15:0] w0, w1, w2;
      int          nbeats;
      int          addr;
      int          err;
      int          first;
   } vec_t;
   vec_t tbl [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One cycle: sample at negedge, check held beats, choose ready for the next edge.
   task automatic tick();
      logic [9:0] cur;
      @(negedge clk);
      cur = {bus_valid, bus_rs, bus_data};
      if (prev_stall && !rst) chk("hold", 32'(cur), 32'(prev_beat));
      case (mode)
         1:       bus_ready = (stall_run >= 7) ? 1'b1 : 1'($urandom_range(0, 1));
         2:       bus_ready = !(bus_valid && bus_rs);
         default: bus_ready = 1'b1;
      endcase
      if (bus_valid && bus_ready && !rst) beats.push_back({bus_rs, bus_data});
      prev_stall = bus_valid && !bus_ready;
      stall_run  = prev_stall ? stall_run + 1 : 0;
      prev_beat  = cur;
      if (!lcd_rst_n) begin
         low_cnt++;
         low_seen = 1'b1;
      end else if (low_seen && !valid_seen) begin
         if (bus_valid) valid_seen = 1'b1;
         else rel_cnt++;
      end
   endtask

   task automatic run_seq(input string nm, input int glitch);
      int n;
      beats.delete();
      low_cnt = 0; rel_cnt = 0; busy_bad = 0;
      low_seen = 1'b0; valid_seen = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, ":busy_on_start"}, 32'(busy), 32'(1));
      chk({nm, ":done_cleared"}, 32'(done), 32'(0));
      n = 0;
      while (!done && n < 20000) begin
         if (n == glitch) start = 1'b1;
         tick();
         start = 1'b0;
         n++;
         if (!done && !busy) busy_bad++;
      end
      chk({nm, ":finished_in_budget"}, 32'(done), 32'(1));
      chk({nm, ":busy_throughout"}, 32'(busy_bad), 32'(0));
   endtask

   // Reference: walk the ROM by the entry rules; timing is one cycle each for
   // fetch, latch and decode plus arg ms per delay entry.
   task automatic verify(input string nm);
      logic [8:0]  exp_q [$];
      logic [15:0] w;
      int          a, t, fv, e, lim;
      a = 0; t = WAIT_CYC; fv = -1; e = 0;
      for (int k = 0; k < 256; k++) begin
         w = rom[k];
         a = k;
         t += 3;
         if (w[15:8] == 8'hFF) break;
         if (w[15:8] == 8'hFE) begin
            t += int'(w[7:0]) * DIV;
         end else begin
            if (fv < 0) fv = t;
            exp_q.push_back({1'b0, w[15:8]});
            exp_q.push_back({1'b1, w[7:0]});
         end
         if (k == 255) e = 1;
      end
      chk({nm, ":beat_count"}, 32'(beats.size()), 32'(exp_q.size()));
      lim = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
      for (int i = 0; i < lim; i++)
         chk($sformatf("%s:beat%0d", nm, i), 32'(beats[i]), 32'(exp_q[i]));
      chk({nm, ":rom_addr"}, 32'(rom_addr), 32'(a));
      chk({nm, ":error"}, 32'(error), 32'(e));
      chk({nm, ":done"}, 32'(done), 32'(1));
      chk({nm, ":busy_off"}, 32'(busy), 32'(0));
      chk({nm, ":valid_off"}, 32'(bus_valid), 32'(0));
      chk({nm, ":rst_low_cycles"}, 32'(low_cnt), 32'(LOW_CYC));
      chk({nm, ":lcd_rst_released"}, 32'(lcd_rst_n), 32'(1));
      if (fv >= 0) chk({nm, ":release_to_first_beat"}, 32'(rel_cnt), 32'(fv));
   endtask

   task automatic load3(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
      rom[0] = w0; rom[1] = w1; rom[2] = w2;
   endtask

   initial begin
      int n;
      tbl[0] = '{16'h8302, 16'h8503, 16'hFF00, 4, 2, 0, 15};
      tbl[1] = '{16'hFE05, 16'h190A, 16'hFF00, 2, 2, 0, 38};
      tbl[2] = '{16'hFE00, 16'hFF00, 16'hFFFF, 0, 1, 0, 0};
      tbl[3] = '{16'hFF00, 16'h1111, 16'h2222, 0, 0, 0, 0};
      tbl[4] = '{16'h1234, 16'hFE01, 16'hFF77, 2, 2, 0, 15};

      load3(16'hFFFF, 16'hFFFF, 16'hFFFF);
      rst = 1'b1; start = 1'b0; bus_ready = 1'b1; mode = 0;
      repeat (3) tick();
      chk("reset:rom_addr", 32'(rom_addr), 32'(0));
      chk("reset:bus_valid", 32'(bus_valid), 32'(0));
      chk("reset:bus_rs", 32'(bus_rs), 32'(0));
      chk("reset:bus_data", 32'(bus_data), 32'(0));
      chk("reset:lcd_rst_n", 32'(lcd_rst_n), 32'(1));
      chk("reset:busy", 32'(busy), 32'(0));
      chk("reset:done", 32'(done), 32'(0));
      chk("reset:error", 32'(error), 32'(0));
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) begin
         load3(tbl[i].w0, tbl[i].w1, tbl[i].w2);
         mode = 0;
         run_seq($sformatf("vec%0d", i), -1);
         verify($sformatf("vec%0d", i));
         chk($sformatf("vec%0d:tbl_beats", i), 32'(beats.size()), 32'(tbl[i].nbeats));
         chk($sformatf("vec%0d:tbl_addr", i), 32'(rom_addr), 32'(tbl[i].addr));
         chk($sformatf("vec%0d:tbl_error", i), 32'(error), 32'(tbl[i].err));
         if (tbl[i].first > 0)
            chk($sformatf("vec%0d:tbl_first", i), 32'(rel_cnt), 32'(tbl[i].first));
      end

      repeat (5) tick();
      chk("sticky:done", 32'(done), 32'(1));
      chk("sticky:busy", 32'(busy), 32'(0));

      load3(16'h8302, 16'h8503, 16'hFF00);
      run_seq("glitch_rstlow", 5);
      verify("glitch_rstlow");
      run_seq("glitch_write", 30);
      verify("glitch_write");

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 256; k++) rom[k] = 16'hFFFF;
         for (int k = 0; k < 9; k++) begin
            if (k % 4 == 3)
               rom[k] = {8'hFE, 8'($urandom_range(0, 2))};
            else
               rom[k] = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
         end
         rom[9] = 16'hFF00;
         mode = 1;
         run_seq($sformatf("rand%0d", r), -1);
         verify($sformatf("rand%0d", r));
      end

      for (int k = 0; k < 256; k++) rom[k] = 16'h161C;
      mode = 0;
      run_seq("no_term", -1);
      verify("no_term");
      chk("no_term:beats_512", 32'(beats.size()), 32'(512));
      chk("no_term:error_set", 32'(error), 32'(1));

      load3(16'h8302, 16'h8503, 16'hFF00);
      mode = 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(bus_valid && bus_rs) && n < 200) begin
         tick();
         n++;
      end
      chk("rst_mid:reached_wr_dat", 32'(bus_valid && bus_rs), 32'(1));
      rst = 1'b1;
      tick();
      chk("rst_mid:bus_valid", 32'(bus_valid), 32'(0));
      chk("rst_mid:lcd_rst_n", 32'(lcd_rst_n), 32'(1));
      chk("rst_mid:busy", 32'(busy), 32'(0));
      chk("rst_mid:rom_addr", 32'(rom_addr), 32'(0));
      chk("rst_mid:done", 32'(done), 32'(0));
      rst = 1'b0;
      mode = 0;
      tick();
      run_seq("after_rst", -1);
      verify("after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hx8352_init_seq.md
Name: hx8352_init_seq

Overview:
- Power-up sequencer for the HX8352 LCD controller.
- Drives the panel hardware reset, then walks the init-command ROM entry by entry. Each entry is a 16-bit word {cmd[15:8], data[7:0]}.
- Normal entries become an index-write plus data-write on the 8080-style bus writer. Delay entries (0xFE) and terminator entries (0xFF) are executed locally.
- Sits between the top-level LCD glue, the init ROM, and the shared bus-writer block; it owns the bus until done.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency. MS_DIV = CLK_FREQ_HZ/1000 cycles per millisecond.
- RST_LOW_MS, 10, lcd_rst_n low time in ms.
- RST_WAIT_MS, 120, wait after reset release before the first ROM fetch, in ms.
- ADDR_W, 8, ROM address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins or re-runs the sequence
- rom_addr  out  ADDR_W  ROM address (registered)
- rom_data  in  16  ROM word; ROM output is registered (1-cycle read latency)
- bus_valid  out  1  beat request to bus writer
- bus_rs  out  1  0 = register index beat, 1 = data beat
- bus_data  out  8  beat payload
- bus_ready  in  1  bus writer accepts the beat when valid&&ready at a clk edge
- lcd_rst_n  out  1  panel hardware reset, active low
- busy  out  1  sequence in progress
- done  out  1  sequence completed (sticky until next start/rst)
- error  out  1  address wrapped without a 0xFF terminator (sticky)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rom_addr=0, bus_valid=0, bus_rs=0, bus_data=0, lcd_rst_n=1, busy=0, done=0, error=0, state=IDLE.
- Reset mid-operation aborts immediately to these values. No bus beat is completed after the rst edge.
- IDLE: on start, clear done/error, set busy=1, lcd_rst_n=0, load the ms counter, go to RST_LOW. start is ignored in every state except IDLE and DONE.
- RST_LOW: hold lcd_rst_n=0 for exactly RST_LOW_MS*MS_DIV cycles, then lcd_rst_n=1 and go to RST_WAIT.
- RST_WAIT: wait RST_WAIT_MS*MS_DIV cycles, set rom_addr=0, go to FETCH.
- FETCH: 1 wait cycle for ROM latency, then go to LATCH.
- LATCH: register entry {cmd, arg}. rom_data is sampled exactly 2 cycles after rom_addr changes.
- DECODE:
  - cmd=0xFF: go to DONE.
  - cmd=0xFE: if arg=0, advance; else go to DELAY.
  - otherwise: go to WR_IDX.
- WR_IDX: bus_valid=1, bus_rs=0, bus_data=cmd. Hold all three stable until the accepting edge, then go to WR_DAT.
- WR_DAT: bus_valid=1, bus_rs=1, bus_data=arg. On acceptance, advance. bus_valid is continuous across the index-to-data transition if bus_ready stays high.
- DELAY: lasts exactly arg*MS_DIV cycles. Uses a ms prescaler plus an 8-bit ms down-counter. Then advance.
- Advance: if rom_addr = 2^ADDR_W-1, set error=1 and go to DONE. Else rom_addr+1 and go to FETCH.
- DONE: busy=0, done=1, bus_valid=0. On start, restart from the IDLE start action (full hardware reset).
- bus_ready high while bus_valid=0 is ignored.
- bus_ready held low stalls indefinitely; there is no timeout.

Decomposition:
- Shared package hx8352_pkg holds:
  - CMD_CUSTOM_DELAY=8'hFE and CMD_CUSTOM_DONE=8'hFF
  - state enum
  - function ms_cycles(ms, freq)
- One natural sub-module: ms_timer. It takes a load pulse and an ms count, and outputs an expired flag. Its prescaler uses MS_DIV, and it is reused by RST_LOW, RST_WAIT and DELAY.

Test Plan:
- Sim parameters CLK_FREQ_HZ=4000 (MS_DIV=4), RST_LOW_MS=2, RST_WAIT_MS=3. Pulse start -> lcd_rst_n low exactly 8 cycles, first rom_addr read 12 cycles after release, busy=1 throughout.
- ROM {83,02},{85,03},{FF,00}, bus_ready tied 1 -> beats (rs,data) = (0,83),(1,02),(0,85),(1,03); done=1, error=0, final rom_addr=2.
- ROM {FE,05},{19,0A},{FF,00} -> no beat for exactly 20 cycles after DECODE of entry 0, then (0,19),(1,0A).
- Random bus_ready stalls up to 7 cycles on a 10-entry ROM -> each beat held stable while valid&&!ready, no dropped or duplicated beats, order preserved.
- ROM with no 0xFF (all {16,1C}) -> 256 entries written, error=1, done=1, busy=0.
- rst asserted during WR_DAT stall -> next cycle: bus_valid=0, lcd_rst_n=1, busy=0, rom_addr=0. A following start gives a complete, correct sequence. start pulsed while busy -> no effect.
